debounce_edge_detect: RTL



---
 rtl/debounce_edge_detect_pkg.sv | 17 +
 rtl/debounce_edge_detect_sync_chain.sv | 30 +++
 rtl/debounce_edge_detect.sv | 115 +++++++++++
 3 files changed

// File: rtl/debounce_edge_detect_pkg.sv
// Shared constants and helpers for the debounce / edge-detect block.
package debounce_edge_detect_pkg;

    // FSM state encoding; bit 0 set means a transition is being qualified.
    localparam logic [1:0] S_LOW       = 2'b00;
    localparam logic [1:0] S_RISE_WAIT = 2'b01;
    localparam logic [1:0] S_HIGH      = 2'b10;
    localparam logic [1:0] S_FALL_WAIT = 2'b11;

    // Debounce counter width: max(1, clog2(n)).
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage : debounce_edge_detect_pkg

// File: rtl/debounce_edge_detect_sync_chain.sv
// Parameterized flop synchronizer for a single asynchronous input.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw input one stage further down the chain each cycle.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // Chain registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_edge_detect.sv
// Debounces one raw asynchronous input into a clean level plus rise/fall strobes.
module debounce_edge_detect
    import debounce_edge_detect_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned        CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             din_sync;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din_raw),
        .dout  (din_sync)
    );

    // Next-state, counter and output decode; counter holds at CNT_MAX on exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            S_LOW: begin
                if (din_sync) begin
                    state_d = S_RISE_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RISE_WAIT: begin
                if (!din_sync) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!din_sync) begin
                    state_d = S_FALL_WAIT;
                    cnt_d   = '0;
                end
            end
            S_FALL_WAIT: begin
                if (din_sync) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase

        busy_d = state_d[0];
    end

    // State, counter and output registers; reset drops everything without a strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign busy  = busy_q;

endmodule : debounce_edge_detect
